vga_timing_gen: RTL and testbench

- Generates the raster scan that the game-object drawing logic consumes.
- Outputs free-running `col_counter`/`row_counter` to the draw logic and accepts back its combinational 8-bit `rgb`.
- Produces registered, mutually aligned `hsync`, `vsync` and blanked `rgb_out` for the VGA pins.
- Provides frame/line ticks so game logic can update object positions during vertical blanking.

---
 rtl/vga_timing_gen.sv | 87 ++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, sync decode and
// registered, blanked VGA pin outputs advancing on a pixel enable.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int unsigned DISP_COLS = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned DISP_ROWS = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter logic        SYNC_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [7:0]  rgb_in,
  output logic [11:0] col_counter,
  output logic [11:0] row_counter,
  output logic        video_on,
  output logic        line_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb_out
);

  localparam int unsigned H_TOTAL =
    DISP_COLS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    DISP_ROWS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(DISP_COLS);
  localparam logic [11:0] V_VIS  = 12'(DISP_ROWS);
  localparam logic [11:0] HS_ON  = 12'(DISP_COLS + H_FP);
  localparam logic [11:0] HS_OFF = 12'(DISP_COLS + H_FP + H_SYNC);
  localparam logic [11:0] VS_ON  = 12'(DISP_ROWS + V_FP);
  localparam logic [11:0] VS_OFF = 12'(DISP_ROWS + V_FP + V_SYNC);

  logic col_last;
  logic row_last;
  logic hs_raw;
  logic vs_raw;

  assign col_last = (col_counter == H_LAST);
  assign row_last = (row_counter == V_LAST);

  assign video_on = (col_counter < H_VIS) &&
                    (row_counter < V_VIS);

  assign hs_raw = (col_counter >= HS_ON) &&
                  (col_counter < HS_OFF);
  assign vs_raw = (row_counter >= VS_ON) &&
                  (row_counter < VS_OFF);

  // Gated by reset so a held reset at (0,0) never looks like a line start.
  assign line_tick  = pix_en && !reset &&
                      (col_counter == 12'd0);
  assign frame_tick = line_tick &&
                      (row_counter == V_VIS);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_counter <= 12'd0;
      row_counter <= 12'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb_out     <= 8'h00;
    end else if (pix_en) begin
      if (col_last) begin
        col_counter <= 12'd0;
        row_counter <= row_last ? 12'd0
                                : row_counter + 12'd1;
      end else begin
        col_counter <= col_counter + 12'd1;
      end
      // Pins share one register stage so they stay aligned.
      hsync   <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs_raw ? SYNC_POL : ~SYNC_POL;
      rgb_out <= video_on ? rgb_in : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench, stimulus pushes expected
// per-cycle observations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HT    = 1056;
  localparam int VT    = 20;
  localparam int DC    = 800;
  localparam int DR    = 12;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [7:0]  rgb_in = 8'h00;
  logic [11:0] col_counter;
  logic [11:0] row_counter;
  logic        video_on;
  logic        line_tick;
  logic        frame_tick;
  logic        hsync;
  logic        vsync;
  logic [7:0]  rgb_out;

  vga_timing_gen #(
    .DISP_ROWS(DR),
    .V_FP(1),
    .V_SYNC(4),
    .V_BP(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .rgb_in(rgb_in),
    .col_counter(col_counter),
    .row_counter(row_counter),
    .video_on(video_on),
    .line_tick(line_tick),
    .frame_tick(frame_tick),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        lt;
    logic        ft;
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
  } obs_t;

  obs_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference raster: enabled-cycle count since reset plus pin regs.
  int         m_n = 0;
  logic       m_hs = 1'b0;
  logic       m_vs = 1'b0;
  logic [7:0] m_rgb = 8'h00;

  function automatic int mcol();
    return m_n % HT;
  endfunction

  function automatic int mrow();
    return (m_n / HT) % VT;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [7:0] c);
    obs_t x;
    int col;
    int row;
    col = mcol();
    row = mrow();
    reset  = r;
    pix_en = e;
    rgb_in = c;
    x.col = 12'(col);
    x.row = 12'(row);
    x.von = (col < DC) && (row < DR);
    x.lt  = e && !r && (col == 0);
    x.ft  = x.lt && (row == DR);
    x.hs  = m_hs;
    x.vs  = m_vs;
    x.rgb = m_rgb;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (r) begin
      m_n = 0;
      m_hs = 1'b0;
      m_vs = 1'b0;
      m_rgb = 8'h00;
    end else if (e) begin
      m_hs = (col >= 840) && (col < 968);
      m_vs = (row >= 13) && (row < 17);
      m_rgb = x.von ? c : 8'h00;
      m_n++;
    end
  endtask

  function automatic logic [7:0] pat();
    return 8'(mcol()) ^ 8'(mrow() << 4) ^ 8'h3C;
  endfunction

  logic prev_hs = 1'b0;
  logic prev_vs = 1'b0;
  logic have_lt = 1'b0;
  logic first_ft = 1'b0;
  int   en_lt = 0;
  int   en_rst = 0;

  always @(negedge clk) begin : mon
    obs_t a;
    obs_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {col_counter, row_counter, video_on, line_tick,
           frame_tick, hsync, vsync, rgb_out};
      check("sb", 64'(a), 64'(e));
      if (hsync && !prev_hs)
        check("hs_rise_col", 64'(col_counter), 64'd841);
      if (!hsync && prev_hs && !reset)
        check("hs_fall_col", 64'(col_counter), 64'd969);
      if (vsync && !prev_vs)
        check("vs_rise_pos", 64'({row_counter, col_counter}),
              64'({12'd13, 12'd1}));
      if (!vsync && prev_vs && !reset)
        check("vs_fall_pos", 64'({row_counter, col_counter}),
              64'({12'd17, 12'd1}));
      prev_hs = hsync;
      prev_vs = vsync;
      if (reset) begin
        have_lt = 1'b0;
        first_ft = 1'b1;
        en_lt = 0;
        en_rst = 0;
      end else begin
        if (line_tick) begin
          if (have_lt) check("line_period", 64'(en_lt), 64'd1056);
          have_lt = 1'b1;
          en_lt = 0;
        end
        if (frame_tick) begin
          check("ft_pos", 64'({row_counter, col_counter}),
                64'({12'd12, 12'd0}));
          if (first_ft)
            check("ft_after_reset", 64'(en_rst), 64'd12672);
          first_ft = 1'b0;
        end
        if (pix_en) begin
          en_lt++;
          en_rst++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 2200; i++)
      step(1'b0, i[0] == 1'b0, 8'hA5);
    while (m_n < FRAME + 5 * HT + 500)
      step(1'b0, 1'b1, (m_n < FRAME) ? 8'hFF : pat());
    step(1'b1, 1'b1, 8'h77);
    repeat (12672 + 1200) step(1'b0, 1'b1, pat());
    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
